// File: rtl/nand_bus_arbiter_if.sv
// Requester-side handshake and pin-request bundle for the NAND bus arbiter.
interface nand_bus_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   gnt;
    logic [8*N_REQ-1:0] m_io_out;
    logic [N_REQ-1:0]   m_io_oe;
    logic [N_REQ-1:0]   m_cle;
    logic [N_REQ-1:0]   m_ale;
    logic [N_REQ-1:0]   m_ren;
    logic [N_REQ-1:0]   m_wen;
    logic [7:0]         m_io_in;
    logic [N_REQ-1:0]   m_rb;

    // Requester engines: drive requests and pin levels, receive grant and flash status.
    modport master (
        output req, m_io_out, m_io_oe, m_cle, m_ale, m_ren, m_wen,
        input  gnt, m_io_in, m_rb
    );

    // Arbiter: observes requester pins, returns grant and flash status.
    modport slave (
        input  req, m_io_out, m_io_oe, m_cle, m_ale, m_ren, m_wen,
        output gnt, m_io_in, m_rb
    );
endinterface

// File: rtl/nand_bus_arbiter.sv
// Transaction-level round-robin arbiter sharing one NAND flash pin set among
// N_REQ engines, with a guard interval between owners and a stall watchdog.
module nand_bus_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned GUARD   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    nand_bus_arbiter_if.slave bus,
    inout  wire  [7:0]        F_IO,
    output logic              F_CLE,
    output logic              F_ALE,
    output logic              F_REN,
    output logic              F_WEN,
    input  logic              F_RB,
    output logic              timeout,
    output logic [1:0]        timeout_id
);

    localparam int unsigned WD_W    = $clog2(TIMEOUT);
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned GUARD_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   blocked_q, blocked_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               timeout_q, timeout_d;
    logic [1:0]         timeout_id_q, timeout_id_d;
    logic [N_REQ-1:0]   prev_wen_q, prev_ren_q;

    logic [N_REQ-1:0]   eligible;
    logic               win;
    logic [N_REQ-1:0]   win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               owner_req;
    logic               owner_act;
    logic               wd_clear;
    logic               wd_hit;
    logic [IDX_W-1:0]   owner_next;
    logic               io_oe;
    logic [7:0]         io_data;

    assign eligible   = bus.req & ~blocked_q;
    assign owner_req  = |(bus.req & gnt_q);
    assign owner_act  = |(((bus.m_wen ^ prev_wen_q) | (bus.m_ren ^ prev_ren_q)) & gnt_q);
    assign wd_clear   = !F_RB || owner_act;
    assign wd_hit     = (wd_q == WD_W'(TIMEOUT - 1));
    assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Round-robin pick: first eligible requester at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        win     = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(N_REQ)) begin
                idx = idx - int'(N_REQ);
            end
            if (!win && eligible[idx]) begin
                win         = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = IDX_W'(idx);
            end
        end
    end

    // Next-state and registered-output logic for the ownership FSM.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        guard_d      = guard_q;
        wd_d         = wd_q;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        blocked_d    = blocked_q & bus.req;

        case (state_q)
            S_IDLE: begin
                if (F_RB && win) begin
                    state_d = S_OWN;
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    wd_d    = '0;
                end
            end
            S_OWN: begin
                if (!owner_req) begin
                    // Voluntary release takes priority over an expiring watchdog.
                    state_d = S_GUARD;
                    gnt_d   = '0;
                    ptr_d   = owner_next;
                    guard_d = GUARD_W'(GUARD - 1);
                end else if (wd_hit && !wd_clear) begin
                    state_d      = S_GUARD;
                    gnt_d        = '0;
                    ptr_d        = owner_next;
                    guard_d      = GUARD_W'(GUARD - 1);
                    timeout_d    = 1'b1;
                    timeout_id_d = owner_q;
                    blocked_d    = blocked_d | gnt_q;
                end else if (wd_clear) begin
                    wd_d = '0;
                end else if (wd_q != {WD_W{1'b1}}) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_GUARD: begin
                if (guard_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            ptr_q        <= '0;
            blocked_q    <= '0;
            guard_q      <= '0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
            prev_wen_q   <= '1;
            prev_ren_q   <= '1;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            blocked_q    <= blocked_d;
            guard_q      <= guard_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
            prev_wen_q   <= bus.m_wen;
            prev_ren_q   <= bus.m_ren;
        end
    end

    // Pin mux from the registered grant; idle levels when nobody owns the bus.
    always_comb begin
        F_CLE   = 1'b0;
        F_ALE   = 1'b0;
        F_REN   = 1'b1;
        F_WEN   = 1'b1;
        io_oe   = 1'b0;
        io_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt_q[i]) begin
                F_CLE   = bus.m_cle[i];
                F_ALE   = bus.m_ale[i];
                F_REN   = bus.m_ren[i];
                F_WEN   = bus.m_wen[i];
                io_oe   = bus.m_io_oe[i];
                io_data = bus.m_io_out[8*i +: 8];
            end
        end
    end

    assign F_IO        = io_oe ? io_data : 8'bz;
    assign bus.m_io_in = F_IO;
    assign bus.m_rb    = gnt_q & {N_REQ{F_RB}};
    assign bus.gnt     = gnt_q;
    assign timeout     = timeout_q;
    assign timeout_id  = timeout_id_q;

endmodule
